// File: rtl/ss_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package ss_pkg;

    localparam int unsigned SS_DIGITS = 4;
    localparam int unsigned SS_BCD_W  = 16;
    localparam logic [SS_BCD_W-1:0] SS_BLANK = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StOpen
    } ss_state_e;

endpackage

// File: rtl/ss_rr_picker.sv
// Combinational round-robin picker: first unmasked request at or after ptr_i, wrapping.
module ss_rr_picker #(
    parameter int unsigned NReq = 3,
    parameter int unsigned IdxW = 2
) (
    input  logic [NReq-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    input  logic [NReq-1:0] mask_i,
    output logic [NReq-1:0] gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [NReq-1:0]   avail;
    logic [2*NReq-1:0] rotated;
    logic [IdxW-1:0]   ofs;
    logic [IdxW:0]     sum;

    always_comb begin
        avail   = req_i & ~mask_i;
        // Doubling the vector makes the wrap-around scan a plain shift.
        rotated = {avail, avail} >> ptr_i;
        valid_o = 1'b0;
        ofs     = '0;
        for (int k = 0; k < NReq; k++) begin
            if (!valid_o && rotated[k]) begin
                valid_o = 1'b1;
                ofs     = IdxW'(k);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, ofs};
        if (sum >= (IdxW + 1)'(NReq)) begin
            sum = sum - (IdxW + 1)'(NReq);
        end
        idx_o = sum[IdxW-1:0];
        gnt_o = valid_o ? (NReq'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/ss_display_arbiter.sv
// Round-robin owner of the shared 4-digit display with a guaranteed minimum hold per grant.
module ss_display_arbiter
    import ss_pkg::*;
#(
    parameter int unsigned          N_REQ       = 3,
    parameter int unsigned          HOLD_CYCLES = 100000000,
    parameter logic [SS_BCD_W-1:0]  IDLE_BCD    = SS_BLANK
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          Req,
    input  logic [SS_BCD_W*N_REQ-1:0] Data,
    output logic [N_REQ-1:0]          Grant,
    output logic [3:0]                BCD3,
    output logic [3:0]                BCD2,
    output logic [3:0]                BCD1,
    output logic [3:0]                BCD0,
    output logic                      Busy,
    output logic                      HoldDone
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_CYCLES - 1);

    ss_state_e             state_q, state_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [SS_BCD_W-1:0]   bcd_q, bcd_d;
    logic                  busy_q, busy_d;
    logic                  hold_done_q, hold_done_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [IdxW-1:0]       owner_q, owner_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic [SS_BCD_W-1:0]   data_arr [N_REQ];
    logic [N_REQ-1:0]      pick_gnt;
    logic [IdxW-1:0]       pick_idx;
    logic                  pick_valid;
    logic                  take;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            data_arr[i] = Data[i*SS_BCD_W +: SS_BCD_W];
        end
    end

    // Masking with the current grant only matters in StOpen; grant is zero in StIdle.
    ss_rr_picker #(
        .NReq (N_REQ),
        .IdxW (IdxW)
    ) u_picker (
        .req_i   (Req),
        .ptr_i   (ptr_q),
        .mask_i  (grant_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        bcd_d       = bcd_q;
        busy_d      = busy_q;
        hold_done_d = hold_done_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        take        = 1'b0;

        case (state_q)
            StIdle: begin
                take = pick_valid;
            end
            StHold: begin
                if (Req[owner_q]) begin
                    bcd_d = data_arr[owner_q];
                end
                if (cnt_q == '0) begin
                    hold_done_d = 1'b1;
                    state_d     = StOpen;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StOpen: begin
                if (pick_valid) begin
                    take = 1'b1;
                end else if (|Req) begin
                    bcd_d = data_arr[owner_q];
                end else begin
                    grant_d     = '0;
                    bcd_d       = IDLE_BCD;
                    busy_d      = 1'b0;
                    hold_done_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (take) begin
            grant_d = pick_gnt;
            owner_d = pick_idx;
            bcd_d   = data_arr[pick_idx];
            cnt_d   = CntLoad;
            busy_d  = 1'b1;
            ptr_d   = (pick_idx == IdxW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            if (HOLD_CYCLES == 1) begin
                hold_done_d = 1'b1;
                state_d     = StOpen;
            end else begin
                hold_done_d = 1'b0;
                state_d     = StHold;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            bcd_q       <= IDLE_BCD;
            busy_q      <= 1'b0;
            hold_done_q <= 1'b0;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            bcd_q       <= bcd_d;
            busy_q      <= busy_d;
            hold_done_q <= hold_done_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
        end
    end

    assign Grant    = grant_q;
    assign {BCD3, BCD2, BCD1, BCD0} = bcd_q;
    assign Busy     = busy_q;
    assign HoldDone = hold_done_q;

endmodule

// File: tb/tb_ss_display_arbiter.sv
// Self-checking bench for ss_display_arbiter with N_REQ=3, HOLD_CYCLES=4.
module tb_ss_display_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [2:0]  Req = '0;
    logic [47:0] Data = '0;
    logic [2:0]  Grant;
    logic [3:0]  BCD3, BCD2, BCD1, BCD0;
    logic        Busy, HoldDone;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [2:0]  g;
        logic [15:0] bcd;
        logic        busy;
        logic        hd;
    } exp_t;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [2:0]  g;
        logic [15:0] bcd;
        logic        busy;
        logic        hd;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[9];

    ss_display_arbiter #(
        .N_REQ       (3),
        .HOLD_CYCLES (4),
        .IDLE_BCD    (16'hFFFF)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .Data     (Data),
        .Grant    (Grant),
        .BCD3     (BCD3),
        .BCD2     (BCD2),
        .BCD1     (BCD1),
        .BCD0     (BCD0),
        .Busy     (Busy),
        .HoldDone (HoldDone)
    );

    always #5 Clk = ~Clk;

    function automatic exp_t mk(input string name, input logic [2:0] g, input logic [15:0] bcd,
                                input logic busy, input logic hd);
        exp_t e;
        e.name = name;
        e.g    = g;
        e.bcd  = bcd;
        e.busy = busy;
        e.hd   = hd;
        return e;
    endfunction

    task automatic check_out();
        exp_t        e;
        logic [15:0] got_bcd;
        e       = sb.pop_front();
        got_bcd = {BCD3, BCD2, BCD1, BCD0};
        total++;
        if (Grant !== e.g || got_bcd !== e.bcd || Busy !== e.busy || HoldDone !== e.hd) begin
            bad++;
            $display("FAIL %s: got grant=%b bcd=%h busy=%b hd=%b, want grant=%b bcd=%h busy=%b hd=%b",
                     e.name, Grant, got_bcd, Busy, HoldDone, e.g, e.bcd, e.busy, e.hd);
        end
        total++;
        if (!$onehot0(Grant) || Busy !== (|Grant)) begin
            bad++;
            $display("FAIL %s/onehot: got grant=%b busy=%b, want one-hot grant with busy=|grant",
                     e.name, Grant, Busy);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic step(input logic rst, input logic [2:0] req, input logic [15:0] d0,
                        input logic [15:0] d1, input logic [15:0] d2, input exp_t e);
        Reset = rst;
        Req   = req;
        Data  = {d2, d1, d0};
        sb.push_back(e);
        @(posedge Clk);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish within 100000 time units");
        $fatal(1);
    end

    initial begin
        exp_t idle_e;
        int   n;

        tbl[0] = '{1'b0, 3'b001, 16'h1234, 16'h0, 16'h0, 3'b001, 16'h1234, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 3'b001, 16'h1234, 16'h0, 16'h0, 3'b001, 16'h1234, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 3'b001, 16'h1111, 16'h0, 16'h0, 3'b001, 16'h1111, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 3'b001, 16'h1111, 16'h0, 16'h0, 3'b001, 16'h1111, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 3'b001, 16'h1111, 16'h0, 16'h0, 3'b001, 16'h1111, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 3'b001, 16'h5678, 16'h0, 16'h0, 3'b001, 16'h5678, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 3'b001, 16'hABCD, 16'h0, 16'h0, 3'b001, 16'hABCD, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 3'b000, 16'hABCD, 16'h0, 16'h0, 3'b000, 16'hFFFF, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 3'b000, 16'h0,    16'h0, 16'h0, 3'b000, 16'hFFFF, 1'b0, 1'b0};

        idle_e = mk("idle", 3'b000, 16'hFFFF, 1'b0, 1'b0);

        // Reset then idle.
        for (int i = 0; i < 2; i++) step(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, idle_e);
        for (int i = 0; i < 10; i++) step(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, idle_e);

        // Single requester: grant, live update in HOLD and OPEN, release.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].d0, tbl[i].d1, tbl[i].d2,
                 mk($sformatf("single[%0d]", i), tbl[i].g, tbl[i].bcd, tbl[i].busy, tbl[i].hd));
        end

        // Contention: each grant spans 4 HOLD cycles plus one OPEN evaluation.
        step(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, idle_e);
        for (int k = 0; k < 20; k++) begin
            n = (k / 5) % 3;
            step(1'b0, 3'b111, 16'h0001, 16'h0002, 16'h0003,
                 mk($sformatf("rotate[%0d]", k), 3'(1 << n), 16'(n + 1), 1'b1, (k % 5) == 4));
        end

        // Early release: owner 0 drops, display frozen until expiry, then no idle gap.
        step(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, idle_e);
        step(1'b0, 3'b001, 16'h0011, 16'h0022, 16'h0033, mk("early0", 3'b001, 16'h0011, 1, 0));
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 3'b010, 16'h0099, 16'h0022, 16'h0033,
                 mk($sformatf("frozen%0d", i), 3'b001, 16'h0011, 1'b1, 1'b0));
        end
        step(1'b0, 3'b010, 16'h0099, 16'h0022, 16'h0033, mk("expire0", 3'b001, 16'h0011, 1, 1));
        step(1'b0, 3'b010, 16'h0099, 16'h0022, 16'h0033, mk("handoff1", 3'b010, 16'h0022, 1, 0));

        // Preemption attempt: Req0 rises mid-hold and must wait for expiry.
        step(1'b0, 3'b010, 16'h0099, 16'h0022, 16'h0033, mk("hold1a", 3'b010, 16'h0022, 1, 0));
        step(1'b0, 3'b011, 16'h0099, 16'h0022, 16'h0033, mk("nopreempt_a", 3'b010, 16'h0022, 1, 0));
        step(1'b0, 3'b011, 16'h0099, 16'h0022, 16'h0033, mk("nopreempt_b", 3'b010, 16'h0022, 1, 0));
        step(1'b0, 3'b011, 16'h0099, 16'h0022, 16'h0033, mk("expire1", 3'b010, 16'h0022, 1, 1));
        step(1'b0, 3'b011, 16'h0099, 16'h0022, 16'h0033, mk("regrant0", 3'b001, 16'h0099, 1, 0));
        step(1'b0, 3'b011, 16'h0099, 16'h0022, 16'h0033, mk("hold0", 3'b001, 16'h0099, 1, 0));

        // Reset mid-hold: nothing remembered, pointer restarts at 0.
        step(1'b1, 3'b100, 16'h0099, 16'h0022, 16'h0033, mk("midreset", 3'b000, 16'hFFFF, 0, 0));
        step(1'b0, 3'b100, 16'h0099, 16'h0022, 16'h0033, mk("postreset", 3'b100, 16'h0033, 1, 0));
        step(1'b0, 3'b100, 16'h0099, 16'h0022, 16'h0033, mk("postreset2", 3'b100, 16'h0033, 1, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ss_display_arbiter.md
Name: ss_display_arbiter

Overview:
- Shares the single 4-digit seven-segment display between N_REQ requesters, such as a counter readout, a status code and a debug value.
- Round-robin arbitration with a guaranteed minimum display time per grant.
- Drives the four BCD digit inputs of the existing seven-segment driver, which sits directly downstream on the same Clk.

Parameters:
N_REQ, 3, number of requesters (2..8)
HOLD_CYCLES, 100000000, minimum Clk cycles a granted requester owns the display (>=1; 1 s at 100 MHz)
IDLE_BCD, 16'hFFFF, digit pattern output when no requester is granted

Ports:
Clk  in  1  system clock, 100 MHz
Reset  in  1  synchronous, active-high reset
Req  in  N_REQ  per-requester display request, level
Data  in  16*N_REQ  requester i digits in Data[16i+15:16i], as {BCD3,BCD2,BCD1,BCD0}
Grant  out  N_REQ  one-hot current owner; all-zero when idle
BCD3, BCD2, BCD1, BCD0  out  4 each  digits to the seven-segment driver
Busy  out  1  high while any grant is active
HoldDone  out  1  high once the minimum hold of the current grant has expired

Behaviour:
- Clocking and reset:
  - One clock domain (Clk). Reset is synchronous and active-high.
  - Reset has priority over every other event.
  - Reset values: Grant=0, BCD3..0=IDLE_BCD, Busy=0, HoldDone=0, pointer=0, state=IDLE, hold counter=0.
- All outputs are registered. The counter width is $clog2(HOLD_CYCLES+1).
- Round-robin pick:
  - Scan Req starting at index pointer and wrap modulo N_REQ; the first asserted index wins.
  - On every new grant to index i, pointer <= (i+1) mod N_REQ.
- State IDLE:
  - If Req==0: stay IDLE; outputs keep their reset values.
  - If Req!=0: at that edge, Grant<=onehot(pick), BCD<=Data[pick], counter<=HOLD_CYCLES-1, Busy<=1, HoldDone<=0.
  - Go to HOLD, or straight to OPEN (with HoldDone<=1) when HOLD_CYCLES==1.
- State HOLD:
  - Counter decrements every cycle.
  - While the owner's Req is high, BCD<=owner Data every cycle (live update, 1-cycle latency).
  - If the owner drops Req, BCD freezes at its last value, and the owner still keeps the display until the counter expires.
  - Other requests are queued and never preempt.
  - When counter==0 at an edge: HoldDone<=1, go to OPEN.
- State OPEN (evaluated every cycle):
  - Another requester pending: re-grant at this edge to pick() among Req with the owner's bit masked. Load its Data, reload the counter, HoldDone<=0, go to HOLD.
  - Only the owner requesting: keep the grant with live BCD update; stay OPEN.
  - No requests: Grant<=0, BCD<=IDLE_BCD, Busy<=0, HoldDone<=0, go to IDLE.
- Simultaneous events:
  - A Req arriving on the same edge as hold expiry is not seen until OPEN is evaluated on the following edge.
  - Exactly one grant change per edge, never more.
- Reset mid-HOLD: everything returns to reset values at that edge; no pending request is remembered.
- Digit values above 9 pass through unchanged; blanking or decoding is the driver's concern.
- Grant is never multi-hot. Busy == |Grant at all times.

Decomposition:
- Shared package ss_pkg:
  - state enum {IDLE, HOLD, OPEN}
  - constant SS_DIGITS=4, SS_BCD_W=16
  - blank pattern constant SS_BLANK=16'hFFFF, used as the IDLE_BCD default
- One natural sub-module: ss_rr_picker, a combinational round-robin picker.
  - Inputs: req vector, pointer, mask.
  - Outputs: one-hot grant, index, any-valid.
- The top level holds the FSM, hold counter and output registers.

Test Plan:
(All scenarios use HOLD_CYCLES=4, N_REQ=3.)
- Reset then idle: Reset 2 cycles, Req=0 for 10 cycles -> Grant=000, BCD3..0=F,F,F,F, Busy=0 throughout.
- Single request: Req=001, Data0=16'h1234 -> next edge Grant=001, digits 1,2,3,4; HoldDone rises after 4 cycles.
  - Then change Data0 to 16'h5678 -> digits show 5678 one cycle later.
  - Drop Req -> one cycle later Grant=000, digits FFFF.
- Contention and rotation: Req=111 held; Data0/1/2 = 16'h0001/16'h0002/16'h0003.
  - Grant sequence is 001,010,100,001.
  - Each grant lasts exactly 5 cycles: 4 HOLD plus 1 OPEN evaluation.
  - Digits track the owner.
- Minimum hold with early release: Req=001, then drop to 000 after 1 cycle while Req=010 is asserted.
  - Grant=001 persists until expiry with BCD frozen, then switches to 010 with no idle gap.
- Preemption attempt: Req1 is granted and in HOLD; raise Req0 at counter=2.
  - Grant stays 010 until hold expiry, then moves to 001.
- Reset mid-HOLD: grant active with counter=2; pulse Reset 1 cycle with Req=100 held.
  - At the Reset edge all outputs return to reset values.
  - On the next edge Grant=100 (pointer restarted at 0, index 2 is the first requester).
